// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: request/writeback bundle between the two writeback
// sources, the arbiter and the register file write port.
// Optional forwarding signals appear when RF_WB_FWD_EN is defined.
interface rf_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                       req0Valid, req1Valid;
  logic                       req0Ready, req1Ready;
  logic [ADDR_WIDTH-1:0]      req0Addr, req1Addr;
  logic [DATA_WIDTH-1:0]      req0Data, req1Data;
  logic                       regWrite;
  logic [ADDR_WIDTH-1:0]      writeAddr;
  logic [DATA_WIDTH-1:0]      dataIn;
  logic [(2**ADDR_WIDTH)-1:0] pendingMask;
`ifdef RF_WB_FWD_EN
  logic [ADDR_WIDTH-1:0]      fwdAddr0, fwdAddr1;
  logic                       fwdHit0, fwdHit1;
  logic [DATA_WIDTH-1:0]      fwdData0, fwdData1;
`endif

  // Source/decode side: drives requests, observes the rf port.
  modport master (
    output req0Valid, req1Valid, req0Addr, req1Addr, req0Data, req1Data,
    input  req0Ready, req1Ready, regWrite, writeAddr, dataIn, pendingMask
`ifdef RF_WB_FWD_EN
    , output fwdAddr0, fwdAddr1
    , input  fwdHit0, fwdHit1, fwdData0, fwdData1
`endif
  );

  // Arbiter side.
  modport slave (
    input  req0Valid, req1Valid, req0Addr, req1Addr, req0Data, req1Data,
    output req0Ready, req1Ready, regWrite, writeAddr, dataIn, pendingMask
`ifdef RF_WB_FWD_EN
    , input  fwdAddr0, fwdAddr1
    , output fwdHit0, fwdHit1, fwdData0, fwdData1
`endif
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-source round-robin writeback arbiter for the single
// rf write port. One hold entry per source, registered rf drive, and a
// pending-write mask for decode stalls.
// Optional forwarding lookup is enabled with the RF_WB_FWD_EN macro.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int NSRC     = 2;

  logic [NSRC-1:0]                 hold_valid_q, hold_valid_d;
  logic [NSRC-1:0][ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [NSRC-1:0][DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                            last_grant_q, last_grant_d;
  logic                            reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0]           write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0]           data_in_q, data_in_d;

  logic [NSRC-1:0]                 req_valid, ready, grant, accept;
  logic [NSRC-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NSRC-1:0][DATA_WIDTH-1:0] req_data;
  logic                            grant_vld, grant_sel;
  logic [NUM_REGS-1:0]             pend;

  assign req_valid = {bus.req1Valid, bus.req0Valid};
  assign req_addr  = {bus.req1Addr,  bus.req0Addr};
  assign req_data  = {bus.req1Data,  bus.req0Data};

  // Round-robin grant: a lone valid hold wins; on a tie the source that
  // did not win last time goes first. Ready allows refill on grant.
  always_comb begin
    grant_vld = |hold_valid_q;
    grant_sel = (&hold_valid_q) ? ~last_grant_q : hold_valid_q[1];
    grant     = '0;
    if (grant_vld) grant[grant_sel] = 1'b1;
    ready     = ~hold_valid_q | grant;
    accept    = req_valid & ready;
  end

  // Hold entry update: accepted x0 writes are dropped, a granted entry
  // empties unless it is refilled at the same edge.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    for (int i = 0; i < NSRC; i++) begin
      if (accept[i] && (req_addr[i] != '0)) begin
        hold_valid_d[i] = 1'b1;
        hold_addr_d[i]  = req_addr[i];
        hold_data_d[i]  = req_data[i];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
  end

  // rf port drive: load the granted entry, otherwise drop regWrite and
  // keep the last address/data.
  always_comb begin
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    data_in_d    = data_in_q;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      reg_write_d  = 1'b1;
      write_addr_d = hold_addr_q[grant_sel];
      data_in_d    = hold_data_q[grant_sel];
      last_grant_d = grant_sel;
    end
  end

  // State registers; reset favours source 0 on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      data_in_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      data_in_q    <= data_in_d;
    end
  end

  // Pending mask: every in-flight destination, x0 never reported.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NSRC; i++)
      if (hold_valid_q[i]) pend[hold_addr_q[i]] = 1'b1;
    if (reg_write_q) pend[write_addr_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.req0Ready   = ready[0];
  assign bus.req1Ready   = ready[1];
  assign bus.regWrite    = reg_write_q;
  assign bus.writeAddr   = write_addr_q;
  assign bus.dataIn      = data_in_q;
  assign bus.pendingMask = pend;

`ifdef RF_WB_FWD_EN
  logic [NSRC-1:0][ADDR_WIDTH-1:0] fwd_addr;
  logic [NSRC-1:0]                 fwd_hit;
  logic [NSRC-1:0][DATA_WIDTH-1:0] fwd_data;

  assign fwd_addr = {bus.fwdAddr1, bus.fwdAddr0};

  // Forward lookup: youngest data wins, hold1 > hold0 > output register.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int n = 0; n < NSRC; n++) begin
      if (fwd_addr[n] != '0) begin
        if (hold_valid_q[1] && hold_addr_q[1] == fwd_addr[n]) begin
          fwd_hit[n]  = 1'b1;
          fwd_data[n] = hold_data_q[1];
        end else if (hold_valid_q[0] && hold_addr_q[0] == fwd_addr[n]) begin
          fwd_hit[n]  = 1'b1;
          fwd_data[n] = hold_data_q[0];
        end else if (reg_write_q && write_addr_q == fwd_addr[n]) begin
          fwd_hit[n]  = 1'b1;
          fwd_data[n] = data_in_q;
        end
      end
    end
  end

  assign bus.fwdHit0  = fwd_hit[0];
  assign bus.fwdHit1  = fwd_hit[1];
  assign bus.fwdData0 = fwd_data[0];
  assign bus.fwdData1 = fwd_data[1];
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus; expected rf writes are queued when
// issued and a negedge monitor pops/compares each regWrite cycle.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk, rst;
  rf_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } exp_t;
  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0Valid = v0; bus.req0Addr = a0; bus.req0Data = d0;
    bus.req1Valid = v1; bus.req1Addr = a1; bus.req1Data = d1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every rf write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.regWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                 bus.writeAddr, bus.dataIn);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_addr", 64'(bus.writeAddr), 64'(e.a));
        chk("wb_data", 64'(bus.dataIn), 64'(e.d));
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
`ifdef RF_WB_FWD_EN
    bus.fwdAddr0 = '0;
    bus.fwdAddr1 = '0;
`endif
    #12;
    chk("rst_regWrite", 64'(bus.regWrite), 64'd0);
    chk("rst_writeAddr", 64'(bus.writeAddr), 64'd0);
    chk("rst_dataIn", 64'(bus.dataIn), 64'd0);
    chk("rst_ready0", 64'(bus.req0Ready), 64'd1);
    chk("rst_ready1", 64'(bus.req1Ready), 64'd1);
    chk("rst_pending", 64'(bus.pendingMask), 64'd0);
    @(negedge clk) rst = 1'b0;

    // Tie right after reset: source 0 first.
    @(posedge clk); #1;
    drive(1, 2, 512, 1, 23, 6549);
    push(2, 512); push(23, 6549);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("tie_pending_e0", 64'(bus.pendingMask), 64'h0080_0004);
    @(posedge clk); #1;
    chk("tie_pending_e1", 64'(bus.pendingMask), 64'h0080_0004);
    repeat (3) @(posedge clk);

    // Repeat tie: last grant was source 1, so source 0 goes first again.
    #1;
    drive(1, 7, 100, 1, 9, 200);
    push(7, 100); push(9, 200);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);

    // Single write timeline on source 0.
    #1;
    drive(1, 5, 879, 0, 0, 0);
    push(5, 879);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("single_pending_e0", 64'(bus.pendingMask), 64'h20);
    chk("single_regWrite_e0", 64'(bus.regWrite), 64'd0);
    @(posedge clk); #1;
    chk("single_regWrite_e1", 64'(bus.regWrite), 64'd1);
    chk("single_pending_e1", 64'(bus.pendingMask), 64'h20);
    @(posedge clk); #1;
    chk("single_pending_e2", 64'(bus.pendingMask), 64'd0);
    chk("single_regWrite_e2", 64'(bus.regWrite), 64'd0);
    repeat (2) @(posedge clk);

    // Tie after a source-0 grant: source 1 goes first.
    #1;
    drive(1, 3, 30, 1, 4, 40);
    push(4, 40); push(3, 30);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);

    // x0 write on source 1 is accepted and dropped.
    #1;
    drive(0, 0, 0, 1, 0, 36);
    chk("x0_ready1", 64'(bus.req1Ready), 64'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("x0_pending_e0", 64'(bus.pendingMask), 64'd0);
    chk("x0_ready1_e0", 64'(bus.req1Ready), 64'd1);
    @(posedge clk); #1;
    chk("x0_regWrite_e1", 64'(bus.regWrite), 64'd0);
    chk("x0_pending_e1", 64'(bus.pendingMask), 64'd0);
    repeat (2) @(posedge clk);

    // Source 0 streams four writes back to back.
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(1, AW'(10 + i), DW'(1000 + i), 0, 0, 0);
      push(AW'(10 + i), DW'(1000 + i));
      chk("stream_ready0", 64'(bus.req0Ready), 64'd1);
      @(posedge clk); #1;
      if (i >= 1) chk("stream_regWrite", 64'(bus.regWrite), 64'd1);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("stream_regWrite_last", 64'(bus.regWrite), 64'd1);
    @(posedge clk); #1;
    chk("stream_regWrite_done", 64'(bus.regWrite), 64'd0);
    repeat (2) @(posedge clk);

`ifdef RF_WB_FWD_EN
    // hold1 (5=36) shadows the output register (5=879).
    #1;
    drive(1, 5, 879, 0, 0, 0);
    push(5, 879);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 5, 36);
    push(5, 36);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    bus.fwdAddr0 = 5;
    bus.fwdAddr1 = 3;
    #1;
    chk("fwd_hit0", 64'(bus.fwdHit0), 64'd1);
    chk("fwd_data0", 64'(bus.fwdData0), 64'd36);
    chk("fwd_hit1_miss", 64'(bus.fwdHit1), 64'd0);
    chk("fwd_data1_miss", 64'(bus.fwdData1), 64'd0);
    bus.fwdAddr0 = '0;
    bus.fwdAddr1 = '0;
    repeat (4) @(posedge clk);
`endif

    // Reset mid-stream: both holds loaded, one write on the rf port.
    #1;
    drive(1, 17, 1717, 1, 18, 1818);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_regWrite", 64'(bus.regWrite), 64'd0);
    chk("mid_rst_writeAddr", 64'(bus.writeAddr), 64'd0);
    chk("mid_rst_dataIn", 64'(bus.dataIn), 64'd0);
    chk("mid_rst_pending", 64'(bus.pendingMask), 64'd0);
    chk("mid_rst_ready0", 64'(bus.req0Ready), 64'd1);
    chk("mid_rst_ready1", 64'(bus.req1Ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_regWrite", 64'(bus.regWrite), 64'd0);
    chk("post_rst_pending", 64'(bus.pendingMask), 64'd0);

    repeat (2) @(posedge clk); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
